serial_word_sequencer: RTL and testbench
========================================

Name: serial_word_sequencer

Overview:
Controller that sequences a bit-serial Moore FSM datapath such as `multiple_of_three_detector`. The datapath has ports clk/rst/in/out, takes one bit per clock, and asserts out when its state is remainder 0.
- Accepts a parallel WIDTH-bit word with a start/busy/done handshake.
- Clears the datapath, streams the word into it one bit per clock, then captures the datapath's verdict into a held result register.
- Sits between a register-level producer and one shared serial FSM instance.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32
MSB_FIRST, 1, 1 = stream bit WIDTH-1 first; 0 = stream bit 0 first

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
data_in  in  WIDTH  word to stream; captured in the cycle start is accepted
abort  in  1  cancel the current word; return to IDLE with no done
busy  out  1  high in every state other than IDLE
done  out  1  one-cycle pulse; result is valid and updated
result  out  1  captured datapath output; held until the next done
fsm_rst  out  1  reset to the serial datapath; high only in CLEAR
fsm_bit  out  1  serial bit to the datapath `in`; 0 outside SHIFT
fsm_out  in  1  datapath `out` (Moore output, registered state)

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- On rst:
  - state=IDLE, shreg=0, cnt=0
  - busy=0, done=0, result=0
  - fsm_rst=0, fsm_bit=0
- rst overrides all other inputs, including mid-operation. No done is produced for an interrupted word.
- Registered state machine with states IDLE, CLEAR, SHIFT, SAMPLE.
- IDLE:
  - start=1 → shreg<=data_in, cnt<=WIDTH, go CLEAR.
  - start=0 → stay.
- CLEAR:
  - fsm_rst=1, driven combinationally from the state; the datapath resets at this cycle's closing edge.
  - Next state is SHIFT.
- SHIFT:
  - fsm_bit = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each edge: shift shreg toward the consumed end, zero-filled, and cnt<=cnt-1.
  - When cnt==1 at the edge, go SAMPLE.
  - Exactly WIDTH SHIFT cycles per word.
- SAMPLE:
  - fsm_out reflects all WIDTH bits.
  - At the edge: result<=fsm_out, done<=1, go IDLE.
- done is registered. It is high exactly in the cycle after SAMPLE, which is an IDLE cycle, and cleared the following cycle.
- Latency:
  - start accepted in cycle 0; CLEAR in cycle 1; SHIFT in cycles 2..WIDTH+1; SAMPLE in cycle WIDTH+2.
  - done is high in cycle WIDTH+3.
  - Back-to-back: start in the done cycle is accepted, so throughput is one word per WIDTH+3 cycles.
- start while busy is ignored: no queuing, and data_in is not re-captured.
- abort=1 in any non-IDLE state:
  - go IDLE next edge; result is unchanged; done stays 0.
  - abort and start together in IDLE: abort has no effect and start is accepted.
- cnt width: clog2(WIDTH+1) bits. cnt never wraps, because the exit is taken at cnt==1.
- Outside SHIFT, fsm_bit=0. The datapath is clocked continuously, so bits it consumes while idle are harmless; CLEAR always precedes streaming.

Decomposition:
Shared package (serial_fsm_pkg) holds:
- the state enum: IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2, SAMPLE=2'd3
- a localparam function for the counter width, clog2(WIDTH+1)

Natural sub-module: serial_shift_reg, a WIDTH-bit parallel-load shift register with load/shift enables and a MSB_FIRST-selectable serial output. The controller FSM, counter and result/done registers stay in the top module. The datapath itself is instantiated outside the block.

Test Plan:
The bench connects `multiple_of_three_detector` (or an equivalent mod-3 reference model) to the fsm_* ports. WIDTH=8 and MSB_FIRST=1 unless stated.
1. rst high for 2 cycles mid-SHIFT of a word → busy=0, done=0, result=0 the next cycle; no done pulse follows.
2. start with data_in=8'h06 (6) → fsm_rst high exactly 1 cycle; fsm_bit sequence 0,0,0,0,0,1,1,0; done in cycle 11; result=1.
3. Back-to-back: 8'h07 then, with start held in the done cycle, 8'hFF → first done result=0, second done 11 cycles later with result=1 (255=3·85).
4. start pulses during busy with data_in=8'h01 → ignored; the original word 8'h00 completes with result=1; only one done pulse.
5. abort in cycle 5 of word 8'h03 → IDLE next cycle; no done; result keeps its prior value; a following start on 8'h0A (10) gives result=0.
6. MSB_FIRST=0, WIDTH=4, data_in=4'b1100 (12) → fsm_bit sequence 0,0,1,1 (LSB first, so the datapath sees binary 0011=3) → result=1; done in cycle 7.

Source files
------------

// File: rtl/serial_fsm_pkg.sv
// rtl/serial_fsm_pkg.sv - shared state encoding and sizing helper for the serial word sequencer
package serial_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        SAMPLE = 2'd3
    } seq_state_e;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - parallel-load, zero-fill shift register with selectable serial end
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = data_in;
        end else if (shift) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign ser_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/serial_word_sequencer.sv
// rtl/serial_word_sequencer.sv - streams a parallel word through an external bit-serial FSM and captures its verdict
module serial_word_sequencer
    import serial_fsm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             fsm_rst,
    output logic             fsm_bit,
    input  logic             fsm_out
);

    localparam int CW = cnt_width(WIDTH);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          result_q, result_d;
    logic          load, shift, ser_bit;

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data_in (data_in),
        .ser_out (ser_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = SHIFT;
            SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                result_d = fsm_out;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over every in-flight action, including the final capture.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign result  = result_q;
    assign fsm_rst = (state_q == CLEAR);
    assign fsm_bit = (state_q == SHIFT) && ser_bit;

endmodule

// File: tb/tb_serial_word_sequencer.sv
// tb/tb_serial_word_sequencer.sv - scoreboard bench with mod-3 datapath models for two sequencer configurations
module tb_serial_word_sequencer;

    typedef struct {
        logic       res;
        logic [7:0] stream;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic       rst, start, abort;
    logic [7:0] data_in;
    logic       busy, done, result, fsm_rst, fsm_bit, fsm_out;

    logic       start2, abort2;
    logic [3:0] data2;
    logic       busy2, done2, result2, frst2, fbit2, fout2;

    serial_word_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
        .busy(busy), .done(done), .result(result),
        .fsm_rst(fsm_rst), .fsm_bit(fsm_bit), .fsm_out(fsm_out)
    );

    serial_word_sequencer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_in(data2), .abort(abort2),
        .busy(busy2), .done(done2), .result(result2),
        .fsm_rst(frst2), .fsm_bit(fbit2), .fsm_out(fout2)
    );

    // Divisible-by-three datapaths: remainder of the bits seen so far, first bit most significant.
    int rem = 0;
    int rem2 = 0;
    always @(posedge clk) rem  <= fsm_rst ? 0 : (rem * 2 + int'(fsm_bit)) % 3;
    always @(posedge clk) rem2 <= frst2 ? 0 : (rem2 * 2 + int'(fbit2)) % 3;
    assign fsm_out = (rem == 0);
    assign fout2   = (rem2 == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = d[3-i];
        return r;
    endfunction

    exp_t sb[$];
    exp_t sb2[$];

    // Monitor for the 8-bit MSB-first instance.
    exp_t       me;
    int         rst_cyc = 0, rst_len = 0, bits_n = 8;
    logic [7:0] cap = '0;
    logic       prev_frst = 1'b0, hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold   = 1'b0;
            bits_n = 8;
        end else begin
            if (fsm_rst) begin
                if (!prev_frst) begin
                    rst_cyc = cyc;
                    rst_len = 0;
                end
                rst_len++;
                bits_n = 0;
                cap    = '0;
            end else if (bits_n < 8) begin
                cap = {cap[6:0], fsm_bit};
                bits_n++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending word at cycle %0d", cyc);
                end else begin
                    me = sb.pop_front();
                    check("result", {31'd0, result}, {31'd0, me.res});
                    check("done_cycle", cyc, me.cyc + 11);
                    check("bit_stream", {24'd0, cap}, {24'd0, me.stream});
                    check("clear_cycle", rst_cyc, me.cyc + 1);
                    check("clear_len", rst_len, 1);
                    hold = me.res;
                end
            end else begin
                check("result_held", {31'd0, result}, {31'd0, hold});
            end
        end
        prev_frst = fsm_rst;
    end

    // Monitor for the 4-bit LSB-first instance.
    exp_t       me2;
    int         rst_cyc2 = 0, bits_n2 = 4;
    logic [3:0] cap2 = '0;
    always @(negedge clk) begin
        if (rst) begin
            bits_n2 = 4;
        end else begin
            if (frst2) begin
                rst_cyc2 = cyc;
                bits_n2  = 0;
                cap2     = '0;
            end else if (bits_n2 < 4) begin
                cap2 = {cap2[2:0], fbit2};
                bits_n2++;
            end
            if (done2) begin
                if (sb2.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done2: got done=1 expected no pending word at cycle %0d", cyc);
                end else begin
                    me2 = sb2.pop_front();
                    check("result2", {31'd0, result2}, {31'd0, me2.res});
                    check("done_cycle2", cyc, me2.cyc + 7);
                    check("bit_stream2", {28'd0, cap2}, {24'd0, me2.stream});
                    check("clear_cycle2", rst_cyc2, me2.cyc + 1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] d);
        exp_t e;
        e.res    = ((d % 8'd3) == 8'd0);
        e.stream = d;
        e.cyc    = cyc;
        sb.push_back(e);
        start   = 1'b1;
        data_in = d;
        tick();
        start   = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic issue2(input logic [3:0] d);
        exp_t e;
        e.res    = ((rev4(d) % 4'd3) == 4'd0);
        e.stream = {4'd0, rev4(d)};
        e.cyc    = cyc;
        sb2.push_back(e);
        start2 = 1'b1;
        data2  = d;
        tick();
        start2 = 1'b0;
        data2  = 4'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 30 cycles expected done at cycle %0d", cyc);
        end
    endtask

    task automatic wait_done2();
        int n = 0;
        while (!done2 && n < 30) begin
            tick();
            n++;
        end
        if (!done2) begin
            n_chk++;
            n_fail++;
            $display("FAIL done2_timeout: got no done within 30 cycles expected done at cycle %0d", cyc);
        end
    endtask

    // Abort in cycle k of the word (start accepted in cycle 0).
    task automatic cancel(input int k);
        repeat (k - 1) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        sb.delete(sb.size() - 1);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;
        start2 = 1'b0; abort2 = 1'b0; data2 = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {31'd0, result}, 32'd0);
        check("reset_fsm_rst", {31'd0, fsm_rst}, 32'd0);
        check("reset_fsm_bit", {31'd0, fsm_bit}, 32'd0);
        check("reset_busy2", {31'd0, busy2}, 32'd0);

        tick();
        issue(8'h06);
        wait_done();

        tick();
        issue(8'h07);
        wait_done();
        issue(8'hFF);
        wait_done();

        tick();
        issue(8'h00);
        repeat (3) begin
            start = 1'b1;
            data_in = 8'h01;
            tick();
            start = 1'b0;
            tick();
        end
        check("busy_while_ignoring_start", {31'd0, busy}, 32'd1);
        wait_done();

        tick();
        issue(8'h03);
        cancel(5);
        repeat (12) tick();
        issue(8'h0A);
        wait_done();

        tick();
        issue(8'h5A);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midword_rst_busy", {31'd0, busy}, 32'd0);
        check("midword_rst_done", {31'd0, done}, 32'd0);
        check("midword_rst_result", {31'd0, result}, 32'd0);
        tick();
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        repeat (15) tick();

        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                cancel(int'($urandom_range(1, 10)));
            end else begin
                wait_done();
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        issue2(4'b1100);
        wait_done2();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            issue2(4'($urandom));
            wait_done2();
        end

        repeat (15) tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        check("scoreboard2_empty", sb2.size(), 32'd0);
        summary();
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running expected completion");
        summary();
        $finish;
    end

endmodule
